// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin burst arbiter.
// Holds the FSM state encoding and the owner-index sizing rule.
package rr_arb_pkg;

    typedef enum logic {IDLE, GRANT} arb_state_e;

    localparam int MAX_REQ = 16;

    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    typedef logic [idx_w(MAX_REQ)-1:0] owner_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first unmasked request at or
// after the start index, wrapping modulo N.
module rr_pick
    import rr_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    input  logic [N-1:0]  excl,
    output logic          found,
    output logic [IW-1:0] index
);

    logic [N-1:0] cand;
    int           s;

    always_comb begin
        cand  = req & ~excl;
        found = 1'b0;
        index = '0;
        s     = 0;
        // Walk from the far end so the nearest candidate wins last.
        for (int k = N - 1; k >= 0; k--) begin
            s = int'(start) + k;
            if (s >= N) s = s - N;
            if (cand[s]) begin
                found = 1'b1;
                index = IW'(s);
            end
        end
    end

endmodule

// File: rtl/rr_burst_arbiter.sv
// Burst-granularity round-robin arbiter in front of a valid/ready
// resource, with per-burst beat counting and a stall watchdog.
module rr_burst_arbiter
    import rr_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*LEN_W-1:0]   req_len,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] owner_id,
    output logic                     busy,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic                     burst_done,
    output logic                     abort
);

    localparam int IW = idx_w(N_REQ);
    localparam int WW = $clog2(TIMEOUT);
    localparam logic [N_REQ-1:0] ONE = N_REQ'(1);
    localparam logic [WW-1:0] WD_HIT = WW'(TIMEOUT - 1);

    arb_state_e        state_q, state_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [LEN_W-1:0]  beats_q, beats_d;
    logic [WW-1:0]     wd_q, wd_d;

    logic              req_own;
    logic              beat;
    logic              last;
    logic              drop;
    logic              wd_hit;
    logic [IW-1:0]     nxt_ptr;

    logic [IW-1:0]     pick_start;
    logic [N_REQ-1:0]  pick_excl;
    logic              pick_found;
    logic [IW-1:0]     pick_idx;
    logic [LEN_W-1:0]  pick_len;

    assign busy       = (state_q == GRANT);
    assign req_own    = req[owner_q];
    assign res_valid  = busy & req_own;
    assign beat       = res_valid & res_ready;
    assign drop       = busy & ~req_own;
    assign last       = beat & (beats_q == '0);
    assign wd_hit     = res_valid & ~beat & (wd_q == WD_HIT);
    assign burst_done = last;
    assign abort      = drop | wd_hit;

    assign gnt      = gnt_q;
    assign owner_id = owner_q;

    assign nxt_ptr = (owner_q == IW'(N_REQ - 1)) ? '0
                   : owner_q + 1'b1;

    // The one picker serves both IDLE arbitration and the
    // zero-bubble hand-over on a last beat (owner excluded).
    assign pick_start = busy ? nxt_ptr : ptr_q;
    assign pick_excl  = busy ? (ONE << owner_q) : '0;
    assign pick_len   = req_len[pick_idx*LEN_W +: LEN_W];

    rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_pick (
        .req   (req),
        .start (pick_start),
        .excl  (pick_excl),
        .found (pick_found),
        .index (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        beats_d = beats_q;
        wd_d    = wd_q;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = GRANT;
                    owner_d = pick_idx;
                    gnt_d   = ONE << pick_idx;
                    beats_d = pick_len;
                    wd_d    = '0;
                end
            end
            GRANT: begin
                if (drop || wd_hit) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = nxt_ptr;
                    wd_d    = '0;
                end else if (last) begin
                    ptr_d = nxt_ptr;
                    wd_d  = '0;
                    if (pick_found) begin
                        owner_d = pick_idx;
                        gnt_d   = ONE << pick_idx;
                        beats_d = pick_len;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end else if (beat) begin
                    beats_d = beats_q - 1'b1;
                    wd_d    = '0;
                end else if (wd_q != '1) begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
            beats_q <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            beats_q <= beats_d;
            wd_q    <= wd_d;
        end
    end

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Directed table plus corner-case sequences and a randomised run
// for the round-robin burst arbiter.
module tb_rr_burst_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] req_len;
    logic [3:0]  gnt;
    logic [1:0]  owner_id;
    logic        busy;
    logic        res_valid;
    logic        res_ready;
    logic        burst_done;
    logic        abort;

    int n_chk;
    int n_fail;

    rr_burst_arbiter #(
        .N_REQ   (4),
        .LEN_W   (4),
        .TIMEOUT (64)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_len    (req_len),
        .gnt        (gnt),
        .owner_id   (owner_id),
        .busy       (busy),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .burst_done (burst_done),
        .abort      (abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [15:0] len;
        logic        rdy;
        logic [3:0]  gnt;
        logic [1:0]  own;
        logic        busy;
        logic        vld;
        logic        done;
        logic        abort;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h",
                     name, $time, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req       = '0;
        req_len   = '0;
        res_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    logic [3:0]  nreq;
    logic [15:0] rlen;
    int          cnt;
    int          waitc[4];
    logic [3:0]  lenv;

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        req       = '0;
        req_len   = '0;
        res_ready = 1'b0;

        // Table: req2 len 3; full rotation; owner 1 drop.
        tbl.push_back('{1, 4'b0100, 16'h0300, 1, 4'b0000, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 4'b0100, 16'h0300, 1, 4'b0100, 2, 1, 1, 0, 0});
        tbl.push_back('{0, 4'b0100, 16'h0300, 1, 4'b0100, 2, 1, 1, 0, 0});
        tbl.push_back('{0, 4'b0100, 16'h0300, 1, 4'b0100, 2, 1, 1, 0, 0});
        tbl.push_back('{0, 4'b0100, 16'h0300, 1, 4'b0100, 2, 1, 1, 1, 0});
        tbl.push_back('{0, 4'b0000, 16'h0300, 1, 4'b0000, 2, 0, 0, 0, 0});
        tbl.push_back('{1, 4'b1111, 16'h0000, 1, 4'b0000, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 4'b1111, 16'h0000, 1, 4'b0001, 0, 1, 1, 1, 0});
        tbl.push_back('{0, 4'b1111, 16'h0000, 1, 4'b0010, 1, 1, 1, 1, 0});
        tbl.push_back('{0, 4'b1111, 16'h0000, 1, 4'b0100, 2, 1, 1, 1, 0});
        tbl.push_back('{0, 4'b1111, 16'h0000, 1, 4'b1000, 3, 1, 1, 1, 0});
        tbl.push_back('{0, 4'b1111, 16'h0000, 1, 4'b0001, 0, 1, 1, 1, 0});
        tbl.push_back('{0, 4'b0000, 16'h0000, 1, 4'b0010, 1, 1, 0, 0, 1});
        tbl.push_back('{0, 4'b0000, 16'h0000, 1, 4'b0000, 1, 0, 0, 0, 0});
        tbl.push_back('{1, 4'b0010, 16'h0070, 1, 4'b0000, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 4'b0010, 16'h0070, 1, 4'b0010, 1, 1, 1, 0, 0});
        tbl.push_back('{0, 4'b0010, 16'h0070, 1, 4'b0010, 1, 1, 1, 0, 0});
        tbl.push_back('{0, 4'b0010, 16'h0070, 1, 4'b0010, 1, 1, 1, 0, 0});
        tbl.push_back('{0, 4'b0000, 16'h0070, 1, 4'b0010, 1, 1, 0, 0, 1});
        tbl.push_back('{0, 4'b1111, 16'h0000, 1, 4'b0000, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 4'b1111, 16'h0000, 1, 4'b0100, 2, 1, 1, 1, 0});
        tbl.push_back('{0, 4'b0000, 16'h0000, 1, 4'b1000, 3, 1, 0, 0, 1});
        tbl.push_back('{0, 4'b0000, 16'h0000, 1, 4'b0000, 3, 0, 0, 0, 0});

        #2;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_owner", 32'(owner_id), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(res_valid), 0);
        chk("rst_done", 32'(burst_done), 0);
        chk("rst_abort", 32'(abort), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            tick();
            req       = tbl[i].req;
            req_len   = tbl[i].len;
            res_ready = tbl[i].rdy;
            #1;
            chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
            chk($sformatf("v%0d_own", i), 32'(owner_id), 32'(tbl[i].own));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
            chk($sformatf("v%0d_vld", i), 32'(res_valid), 32'(tbl[i].vld));
            chk($sformatf("v%0d_done", i), 32'(burst_done), 32'(tbl[i].done));
            chk($sformatf("v%0d_abort", i), 32'(abort), 32'(tbl[i].abort));
        end

        // Watchdog: owner 0 stalled, abort on the 64th granted cycle.
        do_reset();
        tick();
        req       = 4'b0011;
        req_len   = 16'h0000;
        res_ready = 1'b0;
        #1;
        chk("wd_idle", 32'(busy), 0);
        for (int k = 1; k <= 64; k++) begin
            tick();
            #1;
            if (k == 1) chk("wd_gnt0", 32'(gnt), 32'h1);
            chk($sformatf("wd_abort_c%0d", k), 32'(abort),
                (k == 64) ? 32'd1 : 32'd0);
        end
        tick();
        #1;
        chk("wd_release", 32'(gnt), 0);
        tick();
        #1;
        chk("wd_next_gnt", 32'(gnt), 32'h2);

        // Asynchronous reset in the middle of a 5-beat burst.
        do_reset();
        tick();
        req       = 4'b0100;
        req_len   = 16'h0400;
        res_ready = 1'b1;
        #1;
        tick();
        #1;
        chk("ar_gnt", 32'(gnt), 32'h4);
        tick();
        #1;
        chk("ar_beat2", 32'(res_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_gnt0", 32'(gnt), 0);
        chk("ar_busy0", 32'(busy), 0);
        chk("ar_own0", 32'(owner_id), 0);
        chk("ar_vld0", 32'(res_valid), 0);
        chk("ar_done0", 32'(burst_done), 0);
        chk("ar_abort0", 32'(abort), 0);
        tick();
        rst_n   = 1'b1;
        req     = 4'b1111;
        req_len = 16'h0000;
        #1;
        chk("ar_idle", 32'(busy), 0);
        tick();
        #1;
        chk("ar_regnt", 32'(gnt), 32'h1);

        // Randomised traffic with fairness and beat-count checks.
        do_reset();
        rlen    = 16'($urandom);
        req_len = rlen;
        nreq    = '0;
        cnt     = 0;
        for (int i = 0; i < 4; i++) waitc[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            tick();
            req       = nreq;
            res_ready = ($urandom_range(0, 3) != 0);
            #1;
            chk("onehot0", 32'($onehot0(gnt)), 1);
            if (res_valid && res_ready) cnt++;
            if (burst_done) begin
                lenv = rlen[owner_id*4 +: 4];
                chk("beats", 32'(cnt), 32'(lenv) + 32'd1);
                cnt = 0;
            end else if (abort) begin
                cnt = 0;
            end
            if (burst_done || abort) begin
                for (int i = 0; i < 4; i++) begin
                    if (req[i] && owner_id != 2'(i)) begin
                        waitc[i]++;
                        chk($sformatf("starve%0d", i),
                            32'(waitc[i] <= 4), 1);
                    end
                end
            end
            if (busy) waitc[owner_id] = 0;
            nreq = req;
            for (int i = 0; i < 4; i++) begin
                if (req[i] && busy && owner_id == 2'(i)) begin
                    if (burst_done) begin
                        if ($urandom_range(0, 1) == 0) nreq[i] = 1'b0;
                    end else if ($urandom_range(0, 199) == 0) begin
                        nreq[i] = 1'b0;
                    end
                end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                    nreq[i] = 1'b1;
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
